p_to_s: RTL and testbench

Parallel-to-serial converter, the transmit-side counterpart of the 6-bit serial-to-parallel receiver. It accepts DATA_W-bit words on a valid/ready handshake and shifts them out one bit per transfer, LSB first. The serial side carries a valid/ready handshake and a last-bit marker. A one-word holding buffer lets back-to-back words stream with no idle cycle between them.

---
 rtl/p_to_s.sv | 107 ++++++++++
 tb/tb_p_to_s.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/p_to_s.sv
// Parallel-to-serial converter: DATA_W-bit words in on valid/ready, bits out LSB first
// with a last-bit marker. A one-word hold buffer lets consecutive words stream gap-free.
module p_to_s #(
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              ready_a,
    output logic              valid_b,
    output logic              data_b,
    output logic              last_b,
    input  logic              ready_b
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shifter, shifter_nxt;
    logic [DATA_W-1:0] hold, hold_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              accept, xfer, last_xfer;

    assign accept    = valid_a && ready_a;
    assign xfer      = valid_b && ready_b;
    assign last_xfer = xfer && (cnt == CNT_LAST);
    assign data_b    = shifter[0];

    always_comb begin
        state_nxt   = state;
        shifter_nxt = shifter;
        hold_nxt    = hold;
        cnt_nxt     = cnt;
        case (state)
            EMPTY: begin
                if (accept) begin
                    shifter_nxt = data_a;
                    cnt_nxt     = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (last_xfer) begin
                    cnt_nxt = '0;
                    // A word accepted on the final bit goes straight into the shifter.
                    if (accept) begin
                        shifter_nxt = data_a;
                    end else begin
                        shifter_nxt = shifter >> 1;
                        state_nxt   = EMPTY;
                    end
                end else begin
                    if (xfer) begin
                        shifter_nxt = shifter >> 1;
                        cnt_nxt     = cnt + 1'b1;
                    end
                    if (accept) begin
                        hold_nxt  = data_a;
                        state_nxt = FULL;
                    end
                end
            end
            FULL: begin
                if (last_xfer) begin
                    shifter_nxt = hold;
                    cnt_nxt     = '0;
                    state_nxt   = SHIFT;
                end else if (xfer) begin
                    shifter_nxt = shifter >> 1;
                    cnt_nxt     = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            shifter <= '0;
            hold    <= '0;
            cnt     <= '0;
            ready_a <= 1'b0;
            valid_b <= 1'b0;
            last_b  <= 1'b0;
        end else begin
            state   <= state_nxt;
            shifter <= shifter_nxt;
            hold    <= hold_nxt;
            cnt     <= cnt_nxt;
            ready_a <= (state_nxt != FULL);
            valid_b <= (state_nxt != EMPTY);
            last_b  <= (state_nxt != EMPTY) && (cnt_nxt == CNT_LAST);
        end
    end

endmodule

// File: tb/tb_p_to_s.sv
// Bench for p_to_s: directed and random steps checked against a queue-of-bits model,
// plus a short run on an 8-bit instance.
module tb_p_to_s;

    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_a = 1'b0;
    logic [DW-1:0] data_a = '0;
    logic          ready_a;
    logic          valid_b;
    logic          data_b;
    logic          last_b;
    logic          ready_b = 1'b0;

    logic          va8 = 1'b0;
    logic [7:0]    da8 = '0;
    logic          ra8;
    logic          vb8;
    logic          db8;
    logic          lb8;
    logic          rb8 = 1'b0;

    int n_checks = 0;
    int n_err = 0;

    // Model: every bit still owed on the serial side, oldest first.
    bit q_d[$];
    bit q_l[$];
    bit rdy_exp = 1'b0;

    always #5 clk = ~clk;

    p_to_s #(.DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .valid_a(valid_a), .data_a(data_a), .ready_a(ready_a),
        .valid_b(valid_b), .data_b(data_b), .last_b(last_b), .ready_b(ready_b)
    );

    p_to_s #(.DATA_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .valid_a(va8), .data_a(da8), .ready_a(ra8),
        .valid_b(vb8), .data_b(db8), .last_b(lb8), .ready_b(rb8)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("ready_a", ready_a, rdy_exp);
        chk("valid_b", valid_b, q_d.size() > 0);
        if (q_d.size() > 0) begin
            chk("data_b", data_b, q_d[0]);
            chk("last_b", last_b, q_l[0]);
        end else begin
            chk("last_b_idle", last_b, 1'b0);
        end
    endtask

    task automatic step(input logic va, input logic [DW-1:0] da, input logic rb);
        bit acc;
        bit xf;
        valid_a = va;
        data_a  = da;
        ready_b = rb;
        acc = va && rdy_exp;
        xf  = (q_d.size() > 0) && rb;
        @(posedge clk);
        #1;
        if (xf) begin
            void'(q_d.pop_front());
            void'(q_l.pop_front());
        end
        if (acc) begin
            for (int i = 0; i < DW; i++) begin
                q_d.push_back(da[i]);
                q_l.push_back(i == DW - 1);
            end
        end
        rdy_exp = ((q_d.size() + DW - 1) / DW) < 2;
        check_outputs();
    endtask

    initial begin
        logic [7:0] w8;

        // reset state
        #2;
        chk("rst_ready_a", ready_a, 1'b0);
        chk("rst_valid_b", valid_b, 1'b0);
        chk("rst_data_b", data_b, 1'b0);
        chk("rst_last_b", last_b, 1'b0);
        #21 rst_n = 1'b1;
        #1;

        // single word, offered already on the first edge after release
        step(1'b1, 6'b101101, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

        // back-to-back words with valid_a held high
        step(1'b1, 6'h2D, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 6'h12, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

        // ready_b toggled 1,0,0,1,...
        step(1'b1, 6'h3F, 1'b1);
        for (int i = 0; i < 18; i++) step(1'b0, '0, (i % 3) == 0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

        // reach FULL, then stall for 20 cycles with a third word offered
        step(1'b1, 6'h0B, 1'b1);
        step(1'b1, 6'h34, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 6'h15, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 6'h15, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b0, '0, 1'b1);

        // asynchronous reset with a partial word in the shifter and a word in hold
        step(1'b1, 6'h2A, 1'b1);
        step(1'b1, 6'h33, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        #2 rst_n = 1'b0;
        valid_a = 1'b0;
        q_d.delete();
        q_l.delete();
        rdy_exp = 1'b0;
        #1;
        chk("arst_ready_a", ready_a, 1'b0);
        chk("arst_valid_b", valid_b, 1'b0);
        chk("arst_data_b", data_b, 1'b0);
        chk("arst_last_b", last_b, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check_outputs();
        step(1'b1, 6'h01, 1'b1);
        step(1'b1, 6'h01, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);

        // 8-bit instance, word 8'hA5
        w8 = 8'hA5;
        chk("w8_ready_a", ra8, 1'b1);
        va8 = 1'b1;
        da8 = w8;
        rb8 = 1'b1;
        @(posedge clk);
        #1;
        va8 = 1'b0;
        da8 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk("w8_valid_b", vb8, 1'b1);
            chk("w8_data_b", db8, w8[i]);
            chk("w8_last_b", lb8, i == 7);
            @(posedge clk);
            #1;
        end
        chk("w8_valid_b_end", vb8, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
